clk_ratio_ctrl: RTL and testbench

Run-time controller for the processor's divided clock. It generates `clk_out` with a programmable half-period. Ratio changes are accepted through a valid/ready handshake and applied only at a rising boundary of `clk_out`, so no runt pulse is produced. The block also supports glitch-free stop/start and emits single-cycle phase strobes for logic that stays on `clk`.

---
 rtl/clk_ratio_ctrl.sv | 112 +++++++++++
 tb/tb_clk_ratio_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_ctrl.sv
// Run-time programmable clock divider: ratio changes via valid/ready, applied on
// a rising boundary of clk_out, with glitch-free stop/start and phase strobes.
module clk_ratio_ctrl #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_ack,
    output logic             clk_out,
    output logic             rise_en,
    output logic             fall_en,
    output logic [CNT_W-1:0] cur_div,
    output logic             running
);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_SWITCH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] cfg_div_fix;
    logic             at_end;
    logic             accept;

    assign cfg_ready   = (state != ST_SWITCH);
    assign running     = (state != ST_STOP);
    assign accept      = cfg_valid && cfg_ready;
    assign cfg_div_fix = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    assign at_end      = (cnt == cur_div - CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            cnt      <= '0;
            cur_div  <= CNT_W'(RESET_DIV);
            pend_div <= '0;
            clk_out  <= 1'b0;
            rise_en  <= 1'b0;
            fall_en  <= 1'b0;
            cfg_ack  <= 1'b0;
        end else begin
            rise_en <= 1'b0;
            fall_en <= 1'b0;
            cfg_ack <= 1'b0;
            case (state)
                ST_RUN: begin
                    // An accept outranks a stop request; SWITCH handles the stop next cycle.
                    if (accept) begin
                        pend_div <= cfg_div_fix;
                        state    <= ST_SWITCH;
                    end
                    if (!accept && !run && !clk_out) begin
                        state <= ST_STOP;
                        cnt   <= '0;
                    end else if (at_end) begin
                        cnt     <= '0;
                        clk_out <= ~clk_out;
                        rise_en <= ~clk_out;
                        fall_en <= clk_out;
                        if (!accept && !run)
                            state <= ST_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SWITCH: begin
                    if (!run && !clk_out) begin
                        cur_div <= pend_div;
                        cfg_ack <= 1'b1;
                        state   <= ST_STOP;
                        cnt     <= '0;
                    end else if (at_end) begin
                        cnt     <= '0;
                        clk_out <= ~clk_out;
                        rise_en <= ~clk_out;
                        fall_en <= clk_out;
                        // Rising edge (or falling edge when stopping) commits the new ratio.
                        if (!clk_out || !run) begin
                            cur_div <= pend_div;
                            cfg_ack <= 1'b1;
                            state   <= clk_out ? ST_STOP : ST_RUN;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    clk_out <= 1'b0;
                    cnt     <= '0;
                    if (accept) begin
                        pend_div <= cfg_div_fix;
                        cur_div  <= cfg_div_fix;
                        cfg_ack  <= 1'b1;
                    end
                    if (run)
                        state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_ratio_ctrl.sv
// Directed self-checking bench for clk_ratio_ctrl: default ratio, ratio changes,
// zero ratio, stop/start, stop during switch and asynchronous reset.
module tb_clk_ratio_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       cfg_valid;
    logic [3:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_ack;
    logic       clk_out;
    logic       rise_en;
    logic       fall_en;
    logic [3:0] cur_div;
    logic       running;

    int checks   = 0;
    int failures = 0;

    clk_ratio_ctrl #(.CNT_W(4), .RESET_DIV(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_ack   (cfg_ack),
        .clk_out   (clk_out),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .cur_div   (cur_div),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic co, input logic re, input logic fe,
                        input logic ack);
        chk({tag, ".clk_out"}, 32'(co), 32'(clk_out));
        chk({tag, ".rise_en"}, 32'(rise_en), 32'(re));
        chk({tag, ".fall_en"}, 32'(fall_en), 32'(fe));
        chk({tag, ".cfg_ack"}, 32'(cfg_ack), 32'(ack));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        run       = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = 4'd0;
        #12;
        outs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.cur_div", 32'(cur_div), 32'd2);
        chk("rst.cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst.running", 32'(running), 32'd1);
        reset = 1'b0;

        // Default divide-by-4: rise on the 2nd edge, then 2 high / 2 low.
        tick(1); outs("def1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1); outs("def2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1); outs("def3", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1); outs("def4", 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1); outs("def5", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1); outs("def6", 1'b1, 1'b1, 1'b0, 1'b0);

        // Ratio change to 3 offered during the first high cycle.
        chk("r3.ready_before", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1; cfg_div = 4'd3;
        tick(1); outs("r3.acc", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r3.ready_sw", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        tick(1); outs("r3.fall", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("r3.ready_low", 32'(cfg_ready), 32'd0);
        tick(1); outs("r3.low2", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1); outs("r3.ack", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("r3.cur_div", 32'(cur_div), 32'd3);
        chk("r3.ready_after", 32'(cfg_ready), 32'd1);
        tick(2); outs("r3.hi3", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1); outs("r3.fall2", 1'b0, 1'b0, 1'b1, 1'b0);
        tick(2); outs("r3.lo3", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1); outs("r3.rise2", 1'b1, 1'b1, 1'b0, 1'b0);

        // cfg_div = 0 is stored as 1.
        cfg_valid = 1'b1; cfg_div = 4'd0;
        tick(1); chk("z.ready_sw", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        tick(2); outs("z.fall", 1'b0, 1'b0, 1'b1, 1'b0);
        tick(3); outs("z.ack", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("z.cur_div", 32'(cur_div), 32'd1);
        tick(1); outs("z.t1", 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1); outs("z.t2", 1'b1, 1'b1, 1'b0, 1'b0);

        // Back to 2, then stop during the first high cycle.
        cfg_valid = 1'b1; cfg_div = 4'd2;
        tick(1); outs("s.acc", 1'b0, 1'b0, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        tick(1); outs("s.ack2", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("s.cur_div2", 32'(cur_div), 32'd2);
        run = 1'b0;
        tick(1); outs("s.hold", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s.running_hi", 32'(running), 32'd1);
        tick(1); outs("s.fall", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("s.running_off", 32'(running), 32'd0);
        chk("s.ready_stop", 32'(cfg_ready), 32'd1);
        tick(1); outs("s.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        cfg_valid = 1'b1; cfg_div = 4'd5;
        tick(1); outs("s.cfg5", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("s.cur_div5", 32'(cur_div), 32'd5);
        cfg_valid = 1'b0;
        tick(1); outs("s.idle2", 1'b0, 1'b0, 0, 1'b0);
        run = 1'b1;
        tick(1); chk("s.running_on", 32'(running), 32'd1);
        tick(4); outs("s.low5", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1); outs("s.rise5", 1'b1, 1'b1, 1'b0, 1'b0);

        // Stop requested while a switch to 4 is pending in the low phase.
        tick(5); outs("sw.fall", 1'b0, 1'b0, 1'b1, 1'b0);
        cfg_valid = 1'b1; cfg_div = 4'd4;
        tick(1); chk("sw.ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0; run = 1'b0;
        tick(1); outs("sw.ack", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sw.cur_div", 32'(cur_div), 32'd4);
        chk("sw.running", 32'(running), 32'd0);

        // Asynchronous reset while a switch to 7 is pending in the high phase.
        run = 1'b1;
        tick(1); chk("ar.running", 32'(running), 32'd1);
        tick(4); outs("ar.rise", 1'b1, 1'b1, 1'b0, 1'b0);
        cfg_valid = 1'b1; cfg_div = 4'd7;
        tick(1); chk("ar.ready_sw", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        outs("ar.async", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ar.cur_div", 32'(cur_div), 32'd2);
        chk("ar.ready", 32'(cfg_ready), 32'd1);
        chk("ar.running2", 32'(running), 32'd1);
        tick(2); outs("ar.held", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(1); outs("ar.post1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1); outs("ar.post2", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ar.cur_div_post", 32'(cur_div), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
